// File: rtl/perceptron_layer_seq.sv
// Time-multiplexed binary-input perceptron layer: one shared accumulator, one weight per cycle.
// Optional argmax tracking of the strongest neuron is enabled by defining PERCEPTRON_ARGMAX_EN.
module perceptron_layer_seq #(
    parameter int unsigned N_IN      = 8,
    parameter int unsigned N_OUT     = 8,
    parameter int unsigned W_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH = 12,
    localparam int unsigned AW       = $clog2(N_OUT * (N_IN + 1)),
    localparam int unsigned JW       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [W_WIDTH-1:0] wr_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN-1:0]    x_in,
    output logic               out_valid,
    output logic [N_OUT-1:0]   y_out,
`ifdef PERCEPTRON_ARGMAX_EN
    output logic [JW-1:0]      winner,
    output logic               winner_valid,
`endif
    output logic               busy
);

    localparam int unsigned NREG = N_OUT * (N_IN + 1);
    localparam int unsigned IW   = (N_IN > 1) ? $clog2(N_IN) : 1;

    generate
        if (ACC_WIDTH < W_WIDTH + $clog2(N_IN) + 1) begin : g_acc_check
            $error("ACC_WIDTH too small for W_WIDTH and N_IN");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nxt;

    logic signed [W_WIDTH-1:0]   regs [NREG];
    logic [N_IN-1:0]             x_q;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [IW-1:0]               i;
    logic [JW-1:0]               j;
    logic [N_OUT-1:0]            y_reg;

    logic [AW-1:0]               w_idx, t_idx;
    logic signed [ACC_WIDTH-1:0] term, sum, thr_ext;
    logic                        fire, last_i, last_j, wr_ok;
    logic [N_OUT-1:0]            y_upd;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ACCUM;
            ACCUM:   if (last_i && last_j) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_idx   = AW'(j) * AW'(N_IN) + AW'(i);
        t_idx   = AW'(N_OUT * N_IN) + AW'(j);
        term    = x_q[i] ? ACC_WIDTH'(regs[w_idx]) : '0;
        sum     = acc + term;
        thr_ext = ACC_WIDTH'(regs[t_idx]);
        fire    = sum > thr_ext;
        last_i  = (i == IW'(N_IN - 1));
        last_j  = (j == JW'(N_OUT - 1));
        y_upd   = y_reg;
        y_upd[j] = fire;
        wr_ok   = (state == IDLE) && wr_en && (32'(wr_addr) < NREG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // y_out is loaded on the final ACCUM edge so it is already valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            y_reg <= '0;
            y_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q <= x_in;
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
                    end
                end
                ACCUM: begin
                    if (last_i) begin
                        y_reg <= y_upd;
                        acc   <= '0;
                        i     <= '0;
                        j     <= j + 1'b1;
                        if (last_j) y_out <= y_upd;
                    end else begin
                        acc <= sum;
                        i   <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PERCEPTRON_ARGMAX_EN
    logic signed [ACC_WIDTH-1:0] best_acc;
    logic [JW-1:0]               best_idx;
    logic                        take_new;

    // Strict compare keeps the lowest index on ties.
    assign take_new = (j == '0) || (sum > best_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            best_acc <= '0;
            best_idx <= '0;
            winner   <= '0;
        end else if (state == ACCUM && last_i) begin
            if (take_new) begin
                best_acc <= sum;
                best_idx <= j;
            end
            if (last_j) winner <= take_new ? j : best_idx;
        end
    end

    assign winner_valid = (state == DONE);
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Directed scoreboard bench for perceptron_layer_seq (default 8x8 configuration).
module tb_perceptron_layer_seq;

    logic       clk = 1'b0;
    logic       rst, wr_en, in_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data, x_in;
    logic       in_ready, out_valid, busy;
    logic [7:0] y_out;
`ifdef PERCEPTRON_ARGMAX_EN
    logic [2:0] winner;
    logic       winner_valid;
`endif

    always #5 clk = ~clk;

    perceptron_layer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .y_out     (y_out),
`ifdef PERCEPTRON_ARGMAX_EN
        .winner      (winner),
        .winner_valid(winner_valid),
`endif
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [7:0] mw [72];
    logic [7:0] q_y [$];
    logic [2:0] q_w [$];
    logic [7:0] last_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nsum(input logic [7:0] x, input int j);
        int s = 0;
        for (int k = 0; k < 8; k++) if (x[k]) s += int'(mw[j*8+k]);
        return s;
    endfunction

    function automatic logic [7:0] model_y(input logic [7:0] x);
        logic [7:0] y;
        for (int j = 0; j < 8; j++) y[j] = nsum(x, j) > int'(mw[64+j]);
        return y;
    endfunction

    function automatic logic [2:0] model_win(input logic [7:0] x);
        int best = nsum(x, 0);
        logic [2:0] w = 3'd0;
        for (int j = 1; j < 8; j++) begin
            if (nsum(x, j) > best) begin
                best = nsum(x, j);
                w = 3'(j);
            end
        end
        return w;
    endfunction

    task automatic wr(input int addr, input int data, input bit upd);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 7'(addr);
        wr_data = 8'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (upd && addr < 72) mw[addr] = 8'(data);
    endtask

    // drop_wr: write w[0][0]=100 mid-ACCUM (must be ignored);
    // simul_wr: same write alongside in_valid (must be used).
    task automatic run(input logic [7:0] x, input bit drop_wr, input bit simul_wr);
        int cnt = 0;
        while (!in_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("ready_before_run", 32'(in_ready), 32'd1);
        if (simul_wr) begin
            wr_en   = 1'b1;
            wr_addr = 7'd0;
            wr_data = 8'd100;
            mw[0]   = 8'sd100;
        end
        q_y.push_back(model_y(x));
        q_w.push_back(model_win(x));
        x_in     = x;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wr_en    = 1'b0;
        cnt      = 1;
        check("busy_accum", {30'd0, busy, in_ready}, 32'h2);
        wr_addr = 7'd0;
        wr_data = 8'd100;
        while (!out_valid && cnt < 200) begin
            wr_en = drop_wr && (cnt == 10);
            @(negedge clk);
            cnt++;
        end
        wr_en = 1'b0;
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("latency", 32'(cnt), 32'd65);
        last_y = q_y.pop_front();
        check("y_out", 32'(y_out), 32'(last_y));
        check("ready_in_done", {30'd0, busy, in_ready}, 32'h2);
`ifdef PERCEPTRON_ARGMAX_EN
        check("winner", 32'(winner), 32'(q_w.pop_front()));
        check("winner_valid", 32'(winner_valid), 32'd1);
`else
        void'(q_w.pop_front());
`endif
        @(negedge clk);
        check("after_done", {29'd0, out_valid, busy, in_ready}, 32'h1);
    endtask

    initial begin
        int nov;
        rst = 1'b1; wr_en = 1'b0; in_valid = 1'b0;
        wr_addr = '0; wr_data = '0; x_in = '0;
        for (int k = 0; k < 72; k++) mw[k] = '0;

        // Reset defaults and all-zero register file
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {22'd0, y_out, out_valid, busy, in_ready}, 32'h1);
        run(8'hFF, 0, 0);

        // Single-neuron firing
        wr(0, 2, 1); wr(1, 4, 1); wr(2, 2, 1); wr(3, 1, 1);
        wr(4, 5, 1); wr(5, 2, 1); wr(6, 2, 1); wr(7, 2, 1);
        wr(64, 0, 1); wr(65, 127, 1);
        run(8'h01, 0, 0);

        // Signed strict compare on neuron 3; y_out must hold across writes
        for (int k = 24; k < 32; k++) wr(k, -1, 1);
        wr(67, -8, 1);
        check("y_hold", 32'(y_out), 32'(last_y));
        run(8'hFF, 0, 0);
        wr(67, -9, 1);
        run(8'hFF, 0, 0);

        // Write blocking vs. simultaneous write+start
        wr(64, 50, 1);
        wr(72, 127, 0);
        run(8'h01, 1, 0);
        run(8'h01, 0, 1);
        wr(0, 2, 1);

        // Argmax pattern: neurons 2 and 5 reach 40 on x=FF
        for (int k = 16; k < 24; k++) wr(k, 5, 1);
        wr(40, 40, 1);
        run(8'hFF, 0, 0);
        run(8'h01, 0, 0);

        // Reset mid-computation
        @(negedge clk);
        x_in = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_state", {22'd0, y_out, out_valid, busy, in_ready}, 32'h1);
        nov = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) nov++;
        end
        check("no_out_valid_after_abort", 32'(nov), 32'd0);
        for (int k = 0; k < 72; k++) mw[k] = '0;
        run(8'hFF, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perceptron_layer_seq.md
# perceptron_layer_seq

- Parametrised, time-multiplexed successor to the fixed 8×8 combinational perceptron network.
- Computes N_OUT binary-input perceptrons over one N_IN-bit feature vector, using a single shared accumulator with one weight term per cycle.
- Signed weights and per-neuron thresholds live in an internal register file, written at runtime.
- Sits between the input switches (`ui_in`) and the display/output bus (`uo_out`), replacing hard-wired weight constants.

## Interface

Parameters:

- N_IN, 8, number of binary input features
- N_OUT, 8, number of neurons (output bits)
- W_WIDTH, 8, weight/threshold width, signed two's complement
- ACC_WIDTH, 12, signed accumulator width; must be ≥ W_WIDTH + $clog2(N_IN) + 1 (elaboration-time check, so no overflow is possible)
- AW, $clog2(N_OUT*(N_IN+1)), register-file address width (derived, not overridden)

Ports:

- clk, in, 1, clock; all state updates on the rising edge
- rst, in, 1, synchronous active-high reset
- wr_en, in, 1, register-file write strobe
- wr_addr, in, AW, weight at j*N_IN+i; threshold j at N_OUT*N_IN+j
- wr_data, in, W_WIDTH, signed weight/threshold value
- in_valid, in, 1, feature vector valid
- in_ready, out, 1, high only in IDLE
- x_in, in, N_IN, binary feature vector (bit i = feature i)
- out_valid, out, 1, one-cycle pulse when y_out updates
- y_out, out, N_OUT, neuron outputs; bit j = neuron j fires
- busy, out, 1, high in ACCUM and DONE

## Operation

FSM states: IDLE, ACCUM, DONE.

- **IDLE:**
  - in_ready=1.
  - On in_valid: latch x_in, clear acc, set j=0, i=0, go to ACCUM.
- **ACCUM:**
  - Each cycle, acc += x[i] ? w[j][i] : 0 (sign-extended to ACC_WIDTH).
  - At i=N_IN-1, using the final acc including this term: y_reg[j] = (acc > thr[j]), strict signed compare.
  - Then clear acc and i; increment j.
  - After j=N_OUT-1, go to DONE.
- **DONE:**
  - y_out <= y_reg; out_valid=1 for this cycle only.
  - Always go to IDLE next cycle; in_ready=0 in DONE.
- **Writes:**
  - Accepted only in IDLE.
  - wr_en in ACCUM/DONE is silently dropped.
  - Addresses ≥ N_OUT*(N_IN+1) are ignored.
- **Simultaneous wr_en and in_valid in IDLE:** both take effect at the same edge; the computation uses the newly written value.
- **Reset:**
  - All weights and thresholds cleared to 0; FSM to IDLE.
  - y_out=0, out_valid=0, busy=0, in_ready=1 from the first cycle after reset.
  - Reset mid-computation aborts it with no out_valid.
- **All-zero register file:** every neuron computes 0 > 0, so y_out=0.
- **y_out holding:** holds its value between results and is unaffected by writes.

## Timing

- Handshake accepted at edge t:
  - ACCUM occupies cycles t+1 .. t+N_IN*N_OUT.
  - out_valid is high in cycle t+N_IN*N_OUT+1, with y_out valid in the same cycle.
  - in_ready returns high at t+N_IN*N_OUT+2.
- Defaults: 64 ACCUM cycles; out_valid 65 cycles after acceptance; back-to-back throughput is one vector per 66 cycles.
- No combinational path from any input to any output; all outputs are registered.

## Configuration

- PERCEPTRON_ARGMAX_EN defined:
  - Adds outputs `winner` ($clog2(N_OUT) bits) and `winner_valid` (1 bit).
  - Tracks the neuron with the largest final acc; ties go to the lowest index.
  - `winner` updates together with y_out in DONE; `winner_valid` pulses with out_valid.
  - Both reset to 0.
- Undefined: the ports and tracking logic are absent; all other behaviour is identical.

## Test plan

- **Reset defaults:** assert rst for 2 cycles, send x_in=8'hFF -> out_valid exactly 65 cycles after acceptance, y_out=8'h00.
- **Single-neuron firing:** load neuron 0 weights 2,4,2,1,5,2,2,2 with thr 0 and neuron 1 thr 127; x_in=8'h01 -> y_out[0]=1 (sum 2 > 0), y_out[1]=0.
- **Signed strict compare:** neuron 3 weights all -1, thr -8, x_in=8'hFF -> sum -8, y_out[3]=0. Change thr to -9 -> y_out[3]=1.
- **Write blocking:**
  - Write neuron 0 weight 0 = 100 during ACCUM -> dropped; next run gives unchanged y_out.
  - The same write in the IDLE cycle with in_valid -> applied in that run.
- **Reset mid-operation:** pulse rst at cycle 20 of ACCUM -> no out_valid, y_out=0, in_ready=1 next cycle, weights zeroed.
- **Argmax (PERCEPTRON_ARGMAX_EN):** neurons 2 and 5 both reach sum 40, others lower -> winner=2, winner_valid coincident with out_valid.
